// File: rtl/add_sched.sv
// Round-robin scheduler sharing one external W-bit adder among NREQ valid/ready requesters.
// Optional: define ADD_SCHED_SAT_EN for unsigned saturation of the captured sum on carry-out.
module add_sched #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      add_A,
    output logic [W-1:0]      add_B,
    input  logic [W-1:0]      add_Sum,
    input  logic              add_CO,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_sum,
    output logic              resp_co,
    input  logic              resp_ready
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] grant;
    logic           any_valid;

    // Scan from ptr upward, wrapping at NREQ (which need not be a power of two).
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] sel;
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= 32'(NREQ))
                idx = idx - 32'(NREQ);
            sel = idx[IDW-1:0];
            if (!any_valid && req_valid[sel]) begin
                any_valid = 1'b1;
                grant     = sel;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!Reset && state == IDLE && any_valid)
            req_ready[grant] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            ptr        <= '0;
            id_q       <= '0;
            add_A      <= '0;
            add_B      <= '0;
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_co    <= 1'b0;
            resp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        add_A <= req_a[grant*W +: W];
                        add_B <= req_b[grant*W +: W];
                        id_q  <= grant;
                        ptr   <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
`ifdef ADD_SCHED_SAT_EN
                    resp_sum <= add_CO ? '1 : add_Sum;
`else
                    resp_sum <= add_Sum;
`endif
                    resp_co    <= add_CO;
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_sched.sv
// Directed, table-driven bench for add_sched with a behavioural model of the shared adder.
module tb_add_sched;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;
`ifdef ADD_SCHED_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              Clk;
    logic              Reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      add_A;
    logic [W-1:0]      add_B;
    logic [W-1:0]      add_Sum;
    logic              add_CO;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_sum;
    logic              resp_co;
    logic              resp_ready;

    add_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_A     (add_A),
        .add_B     (add_B),
        .add_Sum   (add_Sum),
        .add_CO    (add_CO),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .resp_sum  (resp_sum),
        .resp_co   (resp_co),
        .resp_ready(resp_ready)
    );

    // External combinational adder
    logic [W:0] sum_full;
    assign sum_full = {1'b0, add_A} + {1'b0, add_B};
    assign add_Sum  = sum_full[W-1:0];
    assign add_CO   = sum_full[W];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    typedef struct {
        bit              rst;
        logic [NREQ-1:0] valid;
        logic [63:0]     a;
        logic [63:0]     b;
        logic [NREQ-1:0] exp_ready;
        logic [IDW-1:0]  exp_id;
        logic [W-1:0]    exp_sum;
        logic            exp_co;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 4'b0010, 64'h0000_0000_1234_0000, 64'h0000_0000_4321_0000,
                    4'b0010, 2'd1, 16'h5555, 1'b0};
        vecs[1] = '{1'b1, 4'b1111, 64'h0003_0002_0001_0000, 64'h0010_0010_0010_0010,
                    4'b0001, 2'd0, 16'h0010, 1'b0};
        vecs[2] = '{1'b0, 4'b1111, 64'h0003_0002_0001_0000, 64'h0010_0010_0010_0010,
                    4'b0010, 2'd1, 16'h0011, 1'b0};
        vecs[3] = '{1'b0, 4'b1111, 64'h0003_0002_0001_0000, 64'h0010_0010_0010_0010,
                    4'b0100, 2'd2, 16'h0012, 1'b0};
        vecs[4] = '{1'b0, 4'b1111, 64'h0003_0002_0001_0000, 64'h0010_0010_0010_0010,
                    4'b1000, 2'd3, 16'h0013, 1'b0};
        vecs[5] = '{1'b0, 4'b1111, 64'h0003_0002_0001_0000, 64'h0010_0010_0010_0010,
                    4'b0001, 2'd0, 16'h0010, 1'b0};
        vecs[6] = '{1'b0, 4'b0100, 64'h0000_FFFF_0000_0000, 64'h0000_0002_0000_0000,
                    4'b0100, 2'd2, SAT ? 16'hFFFF : 16'h0001, 1'b1};
        vecs[7] = '{1'b0, 4'b0100, 64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000,
                    4'b0100, 2'd2, SAT ? 16'hFFFF : 16'h0000, 1'b1};
        vecs[8] = '{1'b0, 4'b1001, 64'h00FF_0000_0000_7FFF, 64'h0001_0000_0000_7FFF,
                    4'b1000, 2'd3, 16'h0100, 1'b0};
        vecs[9] = '{1'b0, 4'b1001, 64'h00FF_0000_0000_7FFF, 64'h0001_0000_0000_7FFF,
                    4'b0001, 2'd0, 16'hFFFE, 1'b0};

        Reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;

        // Reset state, then idle with no requests
        repeat (2) @(posedge Clk);
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_resp_valid", 64'(resp_valid), 64'h0);
            check("idle_req_ready", 64'(req_ready), 64'h0);
            check("idle_add_A", 64'(add_A), 64'h0);
            check("idle_add_B", 64'(add_B), 64'h0);
            check("idle_resp_sum", 64'(resp_sum), 64'h0);
            check("idle_resp_co", 64'(resp_co), 64'h0);
            check("idle_resp_id", 64'(resp_id), 64'h0);
        end

        // Each vector: grant, EXEC, RESP, back to IDLE with resp_ready held high
        for (int v = 0; v < NVEC; v++) begin
            if (vecs[v].rst) do_reset();
            req_valid  = vecs[v].valid;
            req_a      = vecs[v].a;
            req_b      = vecs[v].b;
            resp_ready = 1'b1;
            #1;
            check($sformatf("v%0d_grant", v), 64'(req_ready), 64'(vecs[v].exp_ready));
            tick();
            check($sformatf("v%0d_exec_ready", v), 64'(req_ready), 64'h0);
            check($sformatf("v%0d_exec_valid", v), 64'(resp_valid), 64'h0);
            tick();
            check($sformatf("v%0d_resp_valid", v), 64'(resp_valid), 64'h1);
            check($sformatf("v%0d_resp_id", v), 64'(resp_id), 64'(vecs[v].exp_id));
            check($sformatf("v%0d_resp_sum", v), 64'(resp_sum), 64'(vecs[v].exp_sum));
            check($sformatf("v%0d_resp_co", v), 64'(resp_co), 64'(vecs[v].exp_co));
            check($sformatf("v%0d_resp_ready", v), 64'(req_ready), 64'h0);
            tick();
            check($sformatf("v%0d_done_valid", v), 64'(resp_valid), 64'h0);
        end
        req_valid = '0;

        // Back-pressure: result held while resp_ready low; req 3 wins next (ptr = 1)
        do_reset();
        resp_ready = 1'b0;
        req_valid  = 4'b1001;
        req_a      = 64'h0100_0000_0000_0005;
        req_b      = 64'h0200_0000_0000_0003;
        #1;
        check("bp_grant0", 64'(req_ready), 64'h1);
        tick();
        tick();
        check("bp_resp_valid", 64'(resp_valid), 64'h1);
        check("bp_resp_sum", 64'(resp_sum), 64'h0008);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 64'(resp_valid), 64'h1);
            check("bp_hold_sum", 64'(resp_sum), 64'h0008);
            check("bp_hold_id", 64'(resp_id), 64'h0);
            check("bp_hold_co", 64'(resp_co), 64'h0);
            check("bp_hold_ready", 64'(req_ready), 64'h0);
        end
        resp_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(resp_valid), 64'h0);
        check("bp_grant3", 64'(req_ready), 64'b1000);
        tick();
        tick();
        check("bp2_resp_id", 64'(resp_id), 64'h3);
        check("bp2_resp_sum", 64'(resp_sum), 64'h0300);
        req_valid = '0;
        tick();

        // Reset during EXEC discards the operation and clears ptr
        req_valid = 4'b0010;
        req_a     = 64'h0000_0000_0001_0002;
        req_b     = 64'h0000_0000_0001_0003;
        #1;
        check("rx_grant1", 64'(req_ready), 64'b0010);
        tick();
        check("rx_in_exec_A", 64'(add_A), 64'h0001);
        Reset = 1'b1;
        tick();
        check("rx_resp_valid", 64'(resp_valid), 64'h0);
        check("rx_add_A", 64'(add_A), 64'h0);
        Reset     = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rx_no_resp", 64'(resp_valid), 64'h0);
        end
        req_valid = 4'b0011;
        #1;
        check("rx_ptr0_grant", 64'(req_ready), 64'b0001);
        tick();
        tick();
        check("rx_after_id", 64'(resp_id), 64'h0);
        check("rx_after_sum", 64'(resp_sum), 64'h0005);
        req_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
